// File: rtl/queue_write_dispatcher.sv
`timescale 1ns/1ps
// Write-side front end of the FIFO bank: holds one upstream word in a register and
// routes it by its destination field. A word whose FIFO stays full too long is dropped and counted.
module queue_write_dispatcher #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int STALL_LIMIT    = 16,
  parameter int DROP_CNT_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [DATA_BITS-1:0]      in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] buf_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      push_data,
  output logic                      stall,
  output logic [DROP_CNT_BITS-1:0]  drop_count
);

  localparam int DW  = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1;
  localparam int SCW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [DW:0]    QQ_LIMIT   = (DW+1)'(QUEUE_QUANTITY);
  localparam logic [SCW-1:0] STALL_LAST = SCW'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);
  localparam bit             LIMIT_ON   = (STALL_LIMIT != 0);

  typedef enum logic [1:0] {IDLE, HOLD, STALL} state_t;

  state_t                   state, state_d;
  logic [DATA_BITS-1:0]     hold_data;
  logic [DW-1:0]            hold_dest;
  logic [SCW-1:0]           stall_cnt, stall_cnt_d;
  logic [DROP_CNT_BITS-1:0] drop_count_d;
  logic [2**DW-1:0]         full_pad;
  logic                     dest_ok, target_full, fire, drop_now, accept;

  // Padding the full flags lets an out-of-range destination index safely.
  assign full_pad    = (2**DW)'(buf_full);
  assign dest_ok     = {1'b0, hold_dest} < QQ_LIMIT;
  assign target_full = dest_ok & full_pad[hold_dest];

  assign fire     = enb & (state != IDLE) & dest_ok & ~target_full;
  assign drop_now = enb & (state != IDLE) &
                    (~dest_ok | (LIMIT_ON & target_full & (stall_cnt == STALL_LAST)));

  assign push      = fire ? (QUEUE_QUANTITY'(1) << hold_dest) : '0;
  assign push_data = hold_data;
  assign in_ready  = rst & enb & ((state == IDLE) | fire | drop_now);
  assign stall     = (state == STALL);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d      = state;
    stall_cnt_d  = stall_cnt;
    drop_count_d = drop_count;
    if (enb) begin
      case (state)
        IDLE: begin
          if (accept) state_d = HOLD;
        end
        default: begin
          if (fire || drop_now) begin
            state_d     = accept ? HOLD : IDLE;
            stall_cnt_d = '0;
            if (drop_now && (drop_count != '1))
              drop_count_d = drop_count + DROP_CNT_BITS'(1);
          end else begin
            state_d     = STALL;
            stall_cnt_d = (state == HOLD) ? SCW'(1) : stall_cnt + SCW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_dest  <= '0;
      stall_cnt  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_d;
      stall_cnt  <= stall_cnt_d;
      drop_count <= drop_count_d;
      if (accept) begin
        hold_data <= in_data;
        hold_dest <= in_data[DATA_BITS-1 -: DW];
      end
    end
  end

endmodule
